// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch control: req/ack fetch handshake, next-PC select
// with jr > jump > branch priority, and a one-deep pending-redirect buffer for stalled cycles.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   input  logic        imem_ack_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        instr_valid_o,
   output logic        squash_o,
   output logic        misalign_o
);

   typedef enum logic {StBoot, StFetch} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic        squash_q, squash_d;
   logic        misalign_q, misalign_d;

   logic        adv;
   logic        redir_v;
   logic [31:0] redir_addr;
   logic        apply_v;
   logic [31:0] apply_addr;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      misalign_d  = misalign_q;

      redir_v = jr_i | jump_i | branch_i;
      if (jr_i) begin
         redir_addr = jr_target_i;
      end else if (jump_i) begin
         redir_addr = jump_target_i;
      end else begin
         redir_addr = branch_target_i;
      end

      adv        = (state_q == StFetch) & imem_ack_i & ~stall_i;
      // A live pulse in an advancing cycle beats anything already buffered.
      apply_v    = adv & (redir_v | pend_v_q);
      apply_addr = redir_v ? redir_addr : pend_addr_q;
      squash_d   = apply_v;

      unique case (state_q)
         StBoot:  state_d = StFetch;
         StFetch: state_d = StFetch;
         default: state_d = StBoot;
      endcase

      if (adv) begin
         pend_v_d = 1'b0;
         if (apply_v) begin
            pc_d       = {apply_addr[31:2], 2'b00};
            misalign_d = misalign_q | (|apply_addr[1:0]);
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end else if (redir_v) begin
         pend_v_d    = 1'b1;
         pend_addr_d = redir_addr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         pend_v_q    <= 1'b0;
         pend_addr_q <= 32'h0000_0000;
         squash_q    <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
         squash_q    <= squash_d;
         misalign_q  <= misalign_d;
      end
   end

   assign imem_req_o    = (state_q == StFetch);
   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_q + 32'd4;
   assign instr_valid_o = imem_req_o & imem_ack_i;
   assign squash_o      = squash_q;
   assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each acked fetch pushes its expected address/squash/misalign
// record; a negedge monitor pops and compares whenever instr_valid_o is high.
module tb_pc_fetch_ctrl;

   typedef struct packed {
      logic [31:0] addr;
      logic        sq;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, br, jp, jrp, ack;
   logic [31:0] br_t, jp_t, jr_t;
   logic        req, iv, sq, mis;
   logic [31:0] addr, pc, pc4;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   pc_fetch_ctrl #(
      .RESET_PC(32'h0000_3000)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .stall_i        (stall),
      .branch_i       (br),
      .branch_target_i(br_t),
      .jump_i         (jp),
      .jump_target_i  (jp_t),
      .jr_i           (jrp),
      .jr_target_i    (jr_t),
      .imem_ack_i     (ack),
      .imem_req_o     (req),
      .imem_addr_o    (addr),
      .pc_o           (pc),
      .pc_plus4_o     (pc4),
      .instr_valid_o  (iv),
      .squash_o       (sq),
      .misalign_o     (mis)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      if (iv === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL fetch_unexpected: addr=%h sq=%b mis=%b, required no fetch", addr, sq, mis);
         end else begin
            e = exp_q.pop_front();
            if (addr !== e.addr || sq !== e.sq || mis !== e.mis) begin
               errors++;
               $display("FAIL fetch: addr=%h sq=%b mis=%b, required addr=%h sq=%b mis=%b",
                        addr, sq, mis, e.addr, e.sq, e.mis);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // One clock cycle with the given handshake inputs; ev queues an expected fetch record.
   task automatic cyc(input logic a, input logic s, input logic ev, input logic [31:0] ea,
                      input logic esq, input logic emis);
      ack   = a;
      stall = s;
      if (ev) exp_q.push_back('{addr: ea, sq: esq, mis: emis});
      @(posedge clk);
      #1;
      br  = 1'b0;
      jp  = 1'b0;
      jrp = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; stall = 1'b0; ack = 1'b0;
      br = 1'b0; jp = 1'b0; jrp = 1'b0;
      br_t = '0; jp_t = '0; jr_t = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h3000);
      check("reset_req", {31'd0, req}, 32'd0);
      check("reset_pc_plus4", pc4, 32'h3004);
      check("reset_squash", {31'd0, sq}, 32'd0);
      check("reset_misalign", {31'd0, mis}, 32'd0);
      rst = 1'b0;

      // Boot cycle, then zero-wait fetches
      cyc(1, 0, 0, 32'h0, 0, 0);
      check("first_req", {31'd0, req}, 32'd1);
      check("first_addr", addr, 32'h3000);
      cyc(1, 0, 1, 32'h3000, 0, 0);
      cyc(1, 0, 1, 32'h3004, 0, 0);

      // Slow memory then ack under stall
      check("hold_pc_0", pc, 32'h3008);
      cyc(0, 0, 0, 32'h0, 0, 0);
      cyc(0, 0, 0, 32'h0, 0, 0);
      check("hold_pc_1", pc, 32'h3008);
      cyc(1, 1, 1, 32'h3008, 0, 0);
      check("hold_pc_2", pc, 32'h3008);
      cyc(1, 0, 1, 32'h3008, 0, 0);
      check("adv_pc", pc, 32'h300C);

      // Jump while stalled, applied at the first advance
      jp = 1'b1; jp_t = 32'h0040_0100;
      cyc(1, 1, 1, 32'h300C, 0, 0);
      cyc(1, 1, 1, 32'h300C, 0, 0);
      cyc(1, 1, 1, 32'h300C, 0, 0);
      cyc(1, 0, 1, 32'h300C, 0, 0);
      check("jump_pc", pc, 32'h0040_0100);
      cyc(1, 0, 1, 32'h0040_0100, 1, 0);
      check("after_jump_pc", pc, 32'h0040_0104);

      // Simultaneous redirects: jr wins
      jrp = 1'b1; jr_t = 32'h0000_0800;
      jp = 1'b1; jp_t = 32'h0000_1234;
      br = 1'b1; br_t = 32'h0000_5678;
      cyc(1, 0, 1, 32'h0040_0104, 0, 0);
      check("prio_pc", pc, 32'h0800);

      // Pending branch overwritten by a later jump
      br = 1'b1; br_t = 32'h0000_0900;
      cyc(1, 1, 1, 32'h0800, 1, 0);
      jp = 1'b1; jp_t = 32'h0000_0A00;
      cyc(0, 1, 0, 32'h0, 0, 0);
      cyc(1, 0, 1, 32'h0800, 0, 0);
      check("overwrite_pc", pc, 32'h0A00);

      // Misaligned branch, then JR to the top of memory and wrap
      br = 1'b1; br_t = 32'h0000_0202;
      cyc(1, 0, 1, 32'h0A00, 1, 0);
      check("misalign_pc", pc, 32'h0200);
      jrp = 1'b1; jr_t = 32'hFFFF_FFFC;
      cyc(1, 0, 1, 32'h0200, 1, 1);
      check("wrap_pc_plus4", pc4, 32'h0000_0000);
      cyc(1, 0, 1, 32'hFFFF_FFFC, 1, 1);
      check("wrap_pc", pc, 32'h0000_0000);
      cyc(1, 0, 1, 32'h0000_0000, 0, 1);

      // Reset with a pending redirect and an unacked request
      br = 1'b1; br_t = 32'h0000_5550;
      cyc(0, 0, 0, 32'h0, 0, 0);
      rst = 1'b1;
      cyc(0, 0, 0, 32'h0, 0, 0);
      rst = 1'b0;
      check("rst2_pc", pc, 32'h3000);
      check("rst2_req", {31'd0, req}, 32'd0);
      check("rst2_misalign", {31'd0, mis}, 32'd0);
      cyc(1, 0, 0, 32'h0, 0, 0);
      cyc(1, 0, 1, 32'h3000, 0, 0);
      cyc(1, 0, 1, 32'h3004, 0, 0);
      ack = 1'b0;
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
